nib_yummy_fifo: RTL and testbench

Credit-returning input buffer (NIB) at each dynamic-node input port, directly downstream of the sender-side space-available counter. Captures flits from the link on `valid_in`, holds them in a DEPTH-entry FIFO for the crossbar/route logic, and returns one `yummy_out` pulse per flit consumed. The sender's counter starts at DEPTH and decrements per flit sent, so this block never legitimately overflows. Overflow and underflow are flagged as sticky errors.

---
 rtl/dyn_nib_pkg.sv | 28 ++
 rtl/nib_storage.sv | 43 ++++
 rtl/nib_yummy_fifo.sv | 133 +++++++++++++
 tb/tb_nib_yummy_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_nib_pkg.sv
// ---------------------------------------------------------------------------
// dyn_nib_pkg
//
// Constants shared by the dynamic-node input buffer and the sender-side
// space-available counter.  Both ends of a link must agree on buffer depth
// and counter width, so they take their defaults from here.
//
// Contents:
//   DYN_DATA_WIDTH  - flit width in bits
//   DYN_DEPTH       - input buffer entries (sender BUFFER_SIZE)
//   DYN_PTR_BITS    - read/write pointer width
//   DYN_COUNT_BITS  - occupancy width (sender BUFFER_BITS), must hold DEPTH
//   ptr_inc()       - pointer advance with explicit wrap at depth-1
// ---------------------------------------------------------------------------
package dyn_nib_pkg;

  localparam int DYN_DATA_WIDTH = 64;
  localparam int DYN_DEPTH      = 4;
  localparam int DYN_PTR_BITS   = 2;
  localparam int DYN_COUNT_BITS = 3;

  // Wraps explicitly at depth-1 so non-power-of-two depths work; relying on
  // natural pointer overflow would only be correct when depth == 2**bits.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage : dyn_nib_pkg

// File: rtl/nib_storage.sv
// ---------------------------------------------------------------------------
// nib_storage
//
// DEPTH x DATA_WIDTH register array backing the input buffer.  One
// synchronous write port and one asynchronous (combinational) read port, so
// the head entry is visible on rdata in the same cycle raddr points at it.
// The array is deliberately not reset: entries are only ever read after
// they have been written, and occupancy tracking lives in the parent.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from the registered array)
// ---------------------------------------------------------------------------
module nib_storage
  import dyn_nib_pkg::*;
#(
  parameter int DATA_WIDTH = DYN_DATA_WIDTH,
  parameter int DEPTH      = DYN_DEPTH,
  parameter int PTR_BITS   = DYN_PTR_BITS
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_BITS-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_BITS-1:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : nib_storage

// File: rtl/nib_yummy_fifo.sv
// ---------------------------------------------------------------------------
// nib_yummy_fifo
//
// Credit-returning input buffer at a dynamic-node input port.  Flits arriving
// with valid_in are queued; the crossbar/route logic consumes the head with
// thanks_in, and each consumed flit returns exactly one yummy_out pulse to
// the upstream space-available counter on the following cycle.
//
// Because the sender starts with DEPTH credits, overflow and underflow can
// only come from a protocol bug.  They are recorded as sticky error bits
// rather than corrupting state: an overflowing flit is dropped, and an
// underflowing thanks is ignored.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high; discards all contents
//   valid_in       in   flit present on data_in
//   data_in        in   incoming flit
//   thanks_in      in   consumer dequeues the head this cycle
//   valid_out      out  buffer non-empty, data_out is valid
//   data_out       out  head flit
//   yummy_out      out  one-cycle credit return to the sender
//   count_out      out  registered occupancy
//   err_overflow   out  sticky: write while full with no dequeue
//   err_underflow  out  sticky: thanks_in while empty
// ---------------------------------------------------------------------------
module nib_yummy_fifo
  import dyn_nib_pkg::*;
#(
  parameter int DATA_WIDTH = DYN_DATA_WIDTH,
  parameter int DEPTH      = DYN_DEPTH,
  parameter int PTR_BITS   = DYN_PTR_BITS,
  parameter int COUNT_BITS = DYN_COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  thanks_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  yummy_out,
  output logic [COUNT_BITS-1:0] count_out,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [COUNT_BITS-1:0] FULL_COUNT  = COUNT_BITS'(DEPTH);
  localparam logic [COUNT_BITS-1:0] EMPTY_COUNT = '0;

  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  yummy_q, yummy_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;

  logic is_empty;
  logic is_full;
  logic deq;
  logic enq;

  assign is_empty = (count_q == EMPTY_COUNT);
  assign is_full  = (count_q == FULL_COUNT);

  // A full buffer may still accept a flit when the head leaves in the same
  // cycle; the freed slot is the one the new flit's tail write lands in.
  assign deq = thanks_in & ~is_empty;
  assign enq = valid_in & (~is_full | deq);

  nib_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_BITS   (PTR_BITS)
  ) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    yummy_d         = deq;
    err_overflow_d  = err_overflow_q | (valid_in & is_full & ~deq);
    err_underflow_d = err_underflow_q | (thanks_in & is_empty);

    if (enq) begin
      wr_ptr_d = PTR_BITS'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (deq) begin
      rd_ptr_d = PTR_BITS'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end

    // Simultaneous enqueue and dequeue leaves occupancy unchanged.
    unique case ({enq, deq})
      2'b10:   count_d = count_q + COUNT_BITS'(1);
      2'b01:   count_d = count_q - COUNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset drops every queued flit without returning credits for them; the
  // sender resets its counter to DEPTH in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      yummy_q         <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      yummy_q         <= yummy_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign valid_out     = ~is_empty;
  assign yummy_out     = yummy_q;
  assign count_out     = count_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule : nib_yummy_fifo

// File: tb/tb_nib_yummy_fifo.sv
// ---------------------------------------------------------------------------
// tb_nib_yummy_fifo
//
// Drives a DEPTH=4 and a DEPTH=3 buffer with the same input stream and
// compares both against a queue-based reference model of the credit buffer.
// ---------------------------------------------------------------------------
module tb_nib_yummy_fifo;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [63:0] data_in;
  logic        thanks_in;

  logic        valid4, yummy4, ovf4, udf4;
  logic [63:0] data4;
  logic [2:0]  count4;

  logic        valid3, yummy3, ovf3, udf3;
  logic [63:0] data3;
  logic [1:0]  count3;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: queue contents, sticky flags, expected credit.
  logic [63:0] q4[$];
  logic [63:0] q3[$];
  bit          mOvf4, mUdf4, mYum4;
  bit          mOvf3, mUdf3, mYum3;
  int          deqTally4 = 0;
  int          yumTally4 = 0;

  nib_yummy_fifo dut4 (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .thanks_in     (thanks_in),
    .valid_out     (valid4),
    .data_out      (data4),
    .yummy_out     (yummy4),
    .count_out     (count4),
    .err_overflow  (ovf4),
    .err_underflow (udf4)
  );

  nib_yummy_fifo #(
    .DATA_WIDTH (64),
    .DEPTH      (3),
    .PTR_BITS   (2),
    .COUNT_BITS (2)
  ) dut3 (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .thanks_in     (thanks_in),
    .valid_out     (valid3),
    .data_out      (data3),
    .yummy_out     (yummy3),
    .count_out     (count3),
    .err_overflow  (ovf3),
    .err_underflow (udf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One buffer of the model: a queue that drops a flit when already full
  // unless the head leaves in the same cycle, and credits every real pop.
  task automatic modelOne(input int k);
    logic [63:0] q[$];
    int depth;
    bit ovf, udf, yum, doDeq, full;
    if (k == 0) begin
      q = q4; depth = 4; ovf = mOvf4; udf = mUdf4;
    end else begin
      q = q3; depth = 3; ovf = mOvf3; udf = mUdf3;
    end
    if (reset) begin
      q.delete();
      ovf = 0; udf = 0; yum = 0;
    end else begin
      doDeq = thanks_in && (q.size() != 0);
      full  = (q.size() == depth);
      if (thanks_in && q.size() == 0) udf = 1;
      if (valid_in && full && !doDeq) ovf = 1;
      if (doDeq) void'(q.pop_front());
      if (valid_in && (!full || doDeq)) q.push_back(data_in);
      yum = doDeq;
      if (k == 0 && doDeq) deqTally4++;
    end
    if (k == 0) begin
      q4 = q; mOvf4 = ovf; mUdf4 = udf; mYum4 = yum;
    end else begin
      q3 = q; mOvf3 = ovf; mUdf3 = udf; mYum3 = yum;
    end
  endtask

  task automatic checkAll();
    checkOutput("d4 valid_out", 64'(valid4), 64'(q4.size() != 0));
    checkOutput("d4 count_out", 64'(count4), 64'(q4.size()));
    checkOutput("d4 yummy_out", 64'(yummy4), 64'(mYum4));
    checkOutput("d4 err_overflow", 64'(ovf4), 64'(mOvf4));
    checkOutput("d4 err_underflow", 64'(udf4), 64'(mUdf4));
    if (q4.size() != 0) checkOutput("d4 data_out", data4, q4[0]);
    checkOutput("d3 valid_out", 64'(valid3), 64'(q3.size() != 0));
    checkOutput("d3 count_out", 64'(count3), 64'(q3.size()));
    checkOutput("d3 yummy_out", 64'(yummy3), 64'(mYum3));
    checkOutput("d3 err_overflow", 64'(ovf3), 64'(mOvf3));
    checkOutput("d3 err_underflow", 64'(udf3), 64'(mUdf3));
    if (q3.size() != 0) checkOutput("d3 data_out", data3, q3[0]);
    if (yummy4 === 1'b1) yumTally4++;
  endtask

  // Inputs change #1 after the edge, are sampled at the next edge, and the
  // outputs are checked #1 after that edge against the advanced model.
  task automatic applyStimulus(input bit v, input logic [63:0] d, input bit t,
                               input bit r);
    valid_in  = v;
    data_in   = d;
    thanks_in = t;
    reset     = r;
    @(posedge clk);
    modelOne(0);
    modelOne(1);
    #1;
    checkAll();
  endtask

  initial begin
    bit v, t;
    valid_in  = 0;
    data_in   = '0;
    thanks_in = 0;
    reset     = 1;

    $display("[TB] reset");
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(0, 64'h0, 0, 1);
    checkOutput("reset count_out", 64'(count4), 64'd0);
    checkOutput("reset valid_out", 64'(valid4), 64'd0);
    checkOutput("reset yummy_out", 64'(yummy4), 64'd0);

    $display("[TB] fill with A0..A3");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'hA0 + 64'(i), 0, 0);
      checkOutput("fill count", 64'(count4), 64'(i + 1));
    end
    checkOutput("fill head", data4, 64'hA0);

    $display("[TB] drain four");
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain head", data4, 64'hA0 + 64'(i));
      applyStimulus(0, 64'h0, 1, 0);
      checkOutput("drain yummy", 64'(yummy4), 64'd1);
    end
    applyStimulus(0, 64'h0, 0, 0);
    checkOutput("drained yummy low", 64'(yummy4), 64'd0);
    checkOutput("drained valid", 64'(valid4), 64'd0);

    $display("[TB] full with simultaneous write and dequeue");
    applyStimulus(0, 64'h0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 64'hC0 + 64'(i), 0, 0);
    applyStimulus(1, 64'hB0, 1, 0);
    checkOutput("full pass count", 64'(count4), 64'd4);
    checkOutput("full pass overflow", 64'(ovf4), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 64'h0, 1, 0);

    $display("[TB] overflow");
    applyStimulus(0, 64'h0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 64'hD0 + 64'(i), 0, 0);
    applyStimulus(1, 64'hEE, 0, 0);
    checkOutput("overflow flag", 64'(ovf4), 64'd1);
    applyStimulus(0, 64'h0, 0, 0);
    checkOutput("overflow sticky", 64'(ovf4), 64'd1);
    checkOutput("overflow head kept", data4, 64'hD0);

    $display("[TB] underflow");
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(0, 64'h0, 1, 0);
    checkOutput("underflow flag", 64'(udf4), 64'd1);
    applyStimulus(1, 64'h55, 0, 0);
    checkOutput("underflow ptr unchanged", data4, 64'h55);

    $display("[TB] random traffic");
    applyStimulus(0, 64'h0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 3) != 0) && (q4.size() != 0);
      if (q4.size() == 4 && !t) v = ($urandom_range(0, 15) == 0);
      else v = ($urandom_range(0, 2) != 0);
      applyStimulus(v, {$urandom, $urandom}, t, 0);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(1, 64'h11, 0, 0);
    applyStimulus(1, 64'h22, 0, 0);
    checkOutput("pre-reset count", 64'(count4), 64'd2);
    applyStimulus(0, 64'h0, 0, 1);
    checkOutput("post-reset count", 64'(count4), 64'd0);
    checkOutput("post-reset valid", 64'(valid4), 64'd0);
    checkOutput("post-reset yummy", 64'(yummy4), 64'd0);
    checkOutput("post-reset overflow", 64'(ovf4), 64'd0);
    checkOutput("post-reset underflow", 64'(udf4), 64'd0);

    checkOutput("yummy tally", 64'(yumTally4), 64'(deqTally4));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_nib_yummy_fifo
